// File: rtl/qrisc32_avm_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// risc_pack
// Shared types for the qrisc32 Avalon-MM arbiter: grant encoding constants and
// the arbiter state enum. Each state's encoding is also its grant code, so the
// state register drives the grant output directly.
// -----------------------------------------------------------------------------
package risc_pack;

  localparam logic [1:0] GRANT_NONE = 2'd0;
  localparam logic [1:0] GRANT_IR   = 2'd1;
  localparam logic [1:0] GRANT_DR   = 2'd2;
  localparam logic [1:0] GRANT_DW   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = GRANT_NONE,
    GNT_IR = GRANT_IR,
    GNT_DR = GRANT_DR,
    GNT_DW = GRANT_DW
  } arb_state_t;

endpackage

// File: rtl/qrisc32_avm_arbiter_if.sv
// -----------------------------------------------------------------------------
// qrisc32_avm_arbiter_if
// Bundles the three CPU requester ports (instruction read, data read, data
// write), the shared Avalon slave port and the grant indication.
//   ir_*  : fetch-stage read port        dr_* : MEM-stage read port
//   dw_*  : MEM-stage write port         s_*  : shared slave port
//   grant : current owner (0 none, 1 IR, 2 DR, 3 DW)
// Modports: master = arbiter view, slave = requesters + slave view.
// -----------------------------------------------------------------------------
interface qrisc32_avm_arbiter_if;

  logic [31:0] ir_addr;
  logic        ir_rd;
  logic [31:0] ir_data;
  logic        ir_wait_req;

  logic [31:0] dr_addr;
  logic        dr_rd;
  logic [31:0] dr_data;
  logic        dr_wait_req;

  logic [31:0] dw_addr;
  logic        dw_wr;
  logic [31:0] dw_data;
  logic        dw_wait_req;

  logic [31:0] s_addr;
  logic        s_rd;
  logic        s_wr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_wait_req;

  logic [1:0]  grant;

  modport master (
    input  ir_addr, ir_rd, dr_addr, dr_rd, dw_addr, dw_wr, dw_data,
           s_rdata, s_wait_req,
    output ir_data, ir_wait_req, dr_data, dr_wait_req, dw_wait_req,
           s_addr, s_rd, s_wr, s_wdata, grant
  );

  modport slave (
    output ir_addr, ir_rd, dr_addr, dr_rd, dw_addr, dw_wr, dw_data,
           s_rdata, s_wait_req,
    input  ir_data, ir_wait_req, dr_data, dr_wait_req, dw_wait_req,
           s_addr, s_rd, s_wr, s_wdata, grant
  );

endinterface

// File: rtl/qrisc32_arb_pick.sv
// -----------------------------------------------------------------------------
// qrisc32_arb_pick
// Combinational priority picker. Normal order DW > DR > IR; when the starve
// flag is set and IR is requesting, IR jumps to the front.
//   i_ir_rd, i_dr_rd, i_dw_wr : pending requests (already masked by caller)
//   i_starve                  : starve counter has reached its limit
//   o_next                    : owner for the next cycle (IDLE if none)
// -----------------------------------------------------------------------------
module qrisc32_arb_pick
  import risc_pack::*;
(
  input  logic       i_ir_rd,
  input  logic       i_dr_rd,
  input  logic       i_dw_wr,
  input  logic       i_starve,
  output arb_state_t o_next
);

  // NOTE: default first in every always_comb so no path leaves o_next unassigned (no latch).
  always_comb begin
    o_next = IDLE;
    if (i_starve && i_ir_rd) o_next = GNT_IR;
    else if (i_dw_wr)        o_next = GNT_DW;
    else if (i_dr_rd)        o_next = GNT_DR;
    else if (i_ir_rd)        o_next = GNT_IR;
  end

endmodule

// File: rtl/qrisc32_avm_arbiter.sv
// -----------------------------------------------------------------------------
// qrisc32_avm_arbiter
// Arbitrates three CPU requesters onto one Avalon-MM slave with a registered
// grant (one-cycle arbitration latency) and IR starvation protection.
//   clk    : single clock, rising edge
//   areset : asynchronous active-low reset
//   bus    : requester + slave signals (qrisc32_avm_arbiter_if.master)
// Parameter STARVE_MAX (1..255): lost decisions before IR gets top priority.
// -----------------------------------------------------------------------------
module qrisc32_avm_arbiter
  import risc_pack::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic                    clk,
  input  logic                    areset,
  qrisc32_avm_arbiter_if.master   bus
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  arb_state_t w_pick;
  logic [7:0] r_starve_cnt;
  logic [7:0] w_starve_next;

  logic w_strobe;
  logic w_done;
  logic w_decide;
  logic w_ir_req;
  logic w_dr_req;
  logic w_dw_req;
  logic w_starve;

  // Owner's strobe; a non-owner's strobe never reaches the slave.
  always_comb begin
    w_strobe = 1'b0;
    case (r_state)
      GNT_IR:  w_strobe = bus.ir_rd;
      GNT_DR:  w_strobe = bus.dr_rd;
      GNT_DW:  w_strobe = bus.dw_wr;
      default: w_strobe = 1'b0;
    endcase
  end

  assign w_done   = w_strobe & ~bus.s_wait_req;
  assign w_decide = (r_state == IDLE) | w_done;

  // In a completion cycle the owner's strobe is still high, but that request
  // has just been served: mask it so it is not re-granted for a second
  // transfer. This gives exactly one transfer per completion.
  assign w_ir_req = bus.ir_rd & ~(w_done & (r_state == GNT_IR));
  assign w_dr_req = bus.dr_rd & ~(w_done & (r_state == GNT_DR));
  assign w_dw_req = bus.dw_wr & ~(w_done & (r_state == GNT_DW));

  assign w_starve = (r_starve_cnt == 8'(STARVE_MAX));

  qrisc32_arb_pick u_pick (
    .i_ir_rd  (w_ir_req),
    .i_dr_rd  (w_dr_req),
    .i_dw_wr  (w_dw_req),
    .i_starve (w_starve),
    .o_next   (w_pick)
  );

  // Next state and starve counter.
  always_comb begin
    w_next_state  = r_state;
    w_starve_next = r_starve_cnt;
    if (w_decide) begin
      w_next_state = w_pick;
      if ((w_pick == GNT_IR) || !w_ir_req) w_starve_next = 8'd0;
      else if (!w_starve)                  w_starve_next = r_starve_cnt + 8'd1;
    end else if (!w_strobe) begin
      // Owner abandoned its request before completion: release the bus and
      // arbitrate again next cycle.
      w_next_state = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      r_state      <= IDLE;
      r_starve_cnt <= 8'd0;
    end else begin
      r_state      <= w_next_state;
      r_starve_cnt <= w_starve_next;
    end
  end

  // Slave-side mux and per-port wait requests, all from the current owner.
  always_comb begin
    bus.s_addr      = 32'd0;
    bus.s_rd        = 1'b0;
    bus.s_wr        = 1'b0;
    bus.s_wdata     = 32'd0;
    bus.ir_wait_req = 1'b1;
    bus.dr_wait_req = 1'b1;
    bus.dw_wait_req = 1'b1;
    case (r_state)
      GNT_IR: begin
        bus.s_addr      = bus.ir_addr;
        bus.s_rd        = bus.ir_rd;
        bus.ir_wait_req = bus.s_wait_req;
      end
      GNT_DR: begin
        bus.s_addr      = bus.dr_addr;
        bus.s_rd        = bus.dr_rd;
        bus.dr_wait_req = bus.s_wait_req;
      end
      GNT_DW: begin
        bus.s_addr      = bus.dw_addr;
        bus.s_wr        = bus.dw_wr;
        bus.s_wdata     = bus.dw_data;
        bus.dw_wait_req = bus.s_wait_req;
      end
      default: ;
    endcase
  end

  assign bus.ir_data = bus.s_rdata;
  assign bus.dr_data = bus.s_rdata;
  assign bus.grant   = r_state;

endmodule

// File: tb/tb_qrisc32_avm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_qrisc32_avm_arbiter
// Directed bench for qrisc32_avm_arbiter (STARVE_MAX = 3) with a small slave
// memory model and a scoreboard of expected slave transfers.
// -----------------------------------------------------------------------------
module tb_qrisc32_avm_arbiter;

  typedef struct {
    logic [1:0]  grant;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic areset;
  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];

  qrisc32_avm_arbiter_if bus ();

  qrisc32_avm_arbiter #(.STARVE_MAX(3)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave memory: words not yet written return a fixed preload pattern.
  logic [31:0]  mem [256];
  logic [255:0] written = '0;

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    case (idx)
      8'h40:   return 32'hDEAD_BEEF;   // 0x100
      8'h41:   return 32'h0104_0104;   // 0x104
      8'h12:   return 32'h4848_4848;   // 0x048
      8'h20:   return 32'hCAFE_0080;   // 0x080
      default: return 32'h0;
    endcase
  endfunction

  logic [7:0] rd_idx;
  assign rd_idx      = bus.s_addr[9:2];
  assign bus.s_rdata = written[rd_idx] ? mem[rd_idx] : init_word(rd_idx);

  always @(posedge clk) begin
    if (areset && bus.s_wr && !bus.s_wait_req) begin
      mem[bus.s_addr[9:2]]     <= bus.s_wdata;
      written[bus.s_addr[9:2]] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Bus invariants and scoreboard, sampled mid-cycle.
  logic       prev_hold = 1'b0;
  logic [1:0] prev_grant = 2'd0;
  always @(negedge clk) begin
    if (areset) begin
      assert (!(bus.s_rd && bus.s_wr)) else begin
        n_total++;
        $error("FAIL inv_rd_wr: s_rd=%0b s_wr=%0b required not both 1", bus.s_rd, bus.s_wr);
      end
      assert ((32'(!bus.ir_wait_req) + 32'(!bus.dr_wait_req) + 32'(!bus.dw_wait_req)) <= 1) else begin
        n_total++;
        $error("FAIL inv_wait: ir/dr/dw wait_req=%0b%0b%0b required at most one low",
               bus.ir_wait_req, bus.dr_wait_req, bus.dw_wait_req);
      end
      assert (!prev_hold || (bus.grant === prev_grant)) else begin
        n_total++;
        $error("FAIL inv_grant_stable: grant=%0d required %0d", bus.grant, prev_grant);
      end
      if ((bus.s_rd || bus.s_wr) && !bus.s_wait_req) begin
        if (sb.size() == 0) begin
          n_total++;
          $error("FAIL sb_unexpected: transfer grant=%0d addr=0x%08h with empty scoreboard",
                 bus.grant, bus.s_addr);
        end else begin
          exp_t e;
          logic [31:0] d;
          e = sb.pop_front();
          chk("sb_grant", 32'(bus.grant), 32'(e.grant));
          chk("sb_addr", bus.s_addr, e.addr);
          case (bus.grant)
            2'd1:    d = bus.ir_data;
            2'd2:    d = bus.dr_data;
            default: d = bus.s_wdata;
          endcase
          chk("sb_data", d, e.data);
        end
      end
    end
    prev_hold  <= areset && (bus.grant != 2'd0) && (bus.s_rd || bus.s_wr) && bus.s_wait_req;
    prev_grant <= bus.grant;
  end

  initial begin
    areset         = 1'b0;
    bus.ir_addr    = '0; bus.ir_rd = 1'b0;
    bus.dr_addr    = '0; bus.dr_rd = 1'b0;
    bus.dw_addr    = '0; bus.dw_wr = 1'b0; bus.dw_data = '0;
    bus.s_wait_req = 1'b0;

    // Reset state.
    #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_s_rd_wr", {30'd0, bus.s_rd, bus.s_wr}, 32'd0);
    chk("rst_wait", {29'd0, bus.ir_wait_req, bus.dr_wait_req, bus.dw_wait_req}, 32'd7);
    chk("rst_s_addr", bus.s_addr, 32'd0);
    @(negedge clk);
    areset = 1'b1;
    cyc();

    // Single IR read at 0x100.
    bus.ir_addr = 32'h100; bus.ir_rd = 1'b1;
    sb.push_back('{2'd1, 32'h100, 32'hDEAD_BEEF});
    #1;
    chk("ir_pre_grant", 32'(bus.grant), 32'd0);
    chk("ir_pre_wait", 32'(bus.ir_wait_req), 32'd1);
    cyc();
    chk("ir_grant", 32'(bus.grant), 32'd1);
    chk("ir_wait", 32'(bus.ir_wait_req), 32'd0);
    chk("ir_data", bus.ir_data, 32'hDEAD_BEEF);
    chk("ir_s_addr", bus.s_addr, 32'h100);
    cyc();
    chk("ir_idle_after", 32'(bus.grant), 32'd0);
    bus.ir_rd = 1'b0;

    // DW and DR together to 0x40: write first, read sees new data.
    bus.dw_addr = 32'h40; bus.dw_data = 32'h5; bus.dw_wr = 1'b1;
    bus.dr_addr = 32'h40; bus.dr_rd = 1'b1;
    sb.push_back('{2'd3, 32'h40, 32'h5});
    sb.push_back('{2'd2, 32'h40, 32'h5});
    cyc();
    chk("rw_first_dw", 32'(bus.grant), 32'd3);
    chk("rw_s_rd_wr", {30'd0, bus.s_rd, bus.s_wr}, 32'd1);
    chk("rw_dr_wait", 32'(bus.dr_wait_req), 32'd1);
    cyc();
    bus.dw_wr = 1'b0;
    #1;
    chk("rw_then_dr", 32'(bus.grant), 32'd2);
    chk("rw_dr_data", bus.dr_data, 32'h5);
    cyc();
    bus.dr_rd = 1'b0;
    chk("rw_idle", 32'(bus.grant), 32'd0);

    // DR held off by 5 wait cycles.
    bus.s_wait_req = 1'b1;
    bus.dr_addr = 32'h80; bus.dr_rd = 1'b1;
    sb.push_back('{2'd2, 32'h80, 32'hCAFE_0080});
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("wait_grant", 32'(bus.grant), 32'd2);
      chk("wait_s_rd_addr", {bus.s_addr[30:0], bus.s_rd}, {31'h80, 1'b1});
      chk("wait_ports", {29'd0, bus.ir_wait_req, bus.dr_wait_req, bus.dw_wait_req}, 32'd7);
      cyc();
    end
    bus.s_wait_req = 1'b0;
    #1;
    chk("wait_release_dr", 32'(bus.dr_wait_req), 32'd0);
    chk("wait_release_addr", bus.s_addr, 32'h80);
    cyc();
    bus.dr_rd = 1'b0;
    chk("wait_idle", 32'(bus.grant), 32'd0);

    // IR starvation with alternating DW/DR traffic: IR wins the 4th decision.
    bus.ir_addr = 32'h104; bus.ir_rd = 1'b1;
    bus.dw_addr = 32'h44;  bus.dw_data = 32'h11; bus.dw_wr = 1'b1;
    bus.dr_addr = 32'h48;  bus.dr_rd = 1'b1;
    sb.push_back('{2'd3, 32'h44, 32'h11});
    sb.push_back('{2'd2, 32'h48, 32'h4848_4848});
    sb.push_back('{2'd3, 32'h44, 32'h11});
    sb.push_back('{2'd1, 32'h104, 32'h0104_0104});
    cyc();
    chk("starve_d1", 32'(bus.grant), 32'd3);
    cyc();
    chk("starve_d2", 32'(bus.grant), 32'd2);
    cyc();
    chk("starve_d3", 32'(bus.grant), 32'd3);
    cyc();
    chk("starve_d4_ir", 32'(bus.grant), 32'd1);
    chk("starve_cnt_clear", 32'(dut.r_starve_cnt), 32'd0);
    cyc();
    // DW granted next, but every requester withdraws: no transfer, bus released.
    bus.ir_rd = 1'b0; bus.dw_wr = 1'b0; bus.dr_rd = 1'b0;
    #1;
    chk("abandon_grant", 32'(bus.grant), 32'd3);
    chk("abandon_s_wr", 32'(bus.s_wr), 32'd0);
    cyc();
    chk("abandon_idle", 32'(bus.grant), 32'd0);

    // Reset during a GNT_DW wait.
    bus.s_wait_req = 1'b1;
    bus.dw_addr = 32'h60; bus.dw_data = 32'h77; bus.dw_wr = 1'b1;
    cyc();
    chk("rstdw_grant", 32'(bus.grant), 32'd3);
    #2;
    areset = 1'b0;
    #1;
    chk("rstdw_s_wr", 32'(bus.s_wr), 32'd0);
    chk("rstdw_grant0", 32'(bus.grant), 32'd0);
    chk("rstdw_wait", {29'd0, bus.ir_wait_req, bus.dr_wait_req, bus.dw_wait_req}, 32'd7);
    cyc();
    chk("rstdw_hold", 32'(bus.grant), 32'd0);
    #2;
    bus.s_wait_req = 1'b0;
    sb.push_back('{2'd3, 32'h60, 32'h77});
    areset = 1'b1;
    cyc();
    chk("rstdw_regrant", 32'(bus.grant), 32'd3);
    chk("rstdw_dw_wait", 32'(bus.dw_wait_req), 32'd0);
    cyc();
    bus.dw_wr = 1'b0;
    chk("rstdw_idle", 32'(bus.grant), 32'd0);
    chk("rstdw_mem", mem[8'h18], 32'h77);

    cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
